operand_fetch_ctrl: RTL and testbench
=====================================

OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

Interface
REQ-001 Parameter WB_OPC_MAX, default 4'h4: opcodes 4'h0..WB_OPC_MAX write back to Rd; all higher opcodes do not.
REQ-002 One clock; reset is asynchronous and active-low. Port list, clock and reset first (name, direction, width, meaning):
REQ-003 Clk  in  1  rising-edge clock shared with the register file.
REQ-004 Reset_n  in  1  asynchronous active-low reset.
REQ-005 Instr  in  16  instruction word: [15:12] opcode, [11:9] Rd, [8:6] Rs1, [5:3] Rs2, [2:0] unused.
REQ-006 InstrValid  in  1 / InstrReady  out  1  instruction handshake.
REQ-007 RA, RB, RW  out  3 each  register-file read and write addresses.
REQ-008 enReg  out  1  register-file read enable.
REQ-009 RegWrite  out  1  register-file write strobe.
REQ-010 BusW  out  16  write-back data.
REQ-011 BusA, BusB  in  16 each  register-file read data, registered at the edge where enReg=1.
REQ-012 OpValid  out  1 / OpReady  in  1  operand handshake to the execute stage.
REQ-013 OpA, OpB  out  16 each  captured operands; OpCode  out  4  latched opcode.
REQ-014 ResValid  in  1 / Result  in  16  execute-stage result return.
REQ-015 Flush  in  1  synchronous abort of the in-flight instruction.
REQ-016 Busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM has exactly these states: IDLE, READ, CAPT, ISSUE, EXEC, WB.
REQ-018 IDLE: InstrReady=1; when InstrValid=1, latch Instr at the edge and go to READ.
REQ-019 READ (1 cycle): enReg=1, RA=Rs1, RB=Rs2; go to CAPT.
REQ-020 CAPT (1 cycle): capture BusA into OpA and BusB into OpB at the edge; go to ISSUE.
REQ-021 ISSUE: OpValid=1; OpA, OpB and OpCode are held stable until OpValid&&OpReady.
REQ-022 On the ISSUE handshake, a write-back opcode goes to EXEC; any other opcode goes to IDLE.
REQ-023 Latency: accept at edge k gives enReg in cycle k+1 and OpValid from cycle k+3.
REQ-024 EXEC: wait for ResValid; on ResValid, latch Result into BusW and go to WB.
REQ-025 WB (1 cycle): RW=Rd; RegWrite=1 only if Rd!=0; then go to IDLE.
REQ-026 enReg and RegWrite are single-cycle pulses and are never high in the same cycle.
REQ-027 ResValid outside EXEC and OpReady outside ISSUE are ignored.
REQ-028 Flush in READ, CAPT, ISSUE or EXEC returns to IDLE on the next edge with no RegWrite; Flush in WB or IDLE is ignored.
REQ-029 A new instruction is never accepted before the previous WB/IDLE return.
REQ-030 A read of a register follows its write by at least one edge, so no bypass is required.

Reset
REQ-031 While Reset_n=0: state=IDLE; all outputs 0 except InstrReady=1.
REQ-032 Reset outputs: OpA=OpB=BusW=0, RA=RB=RW=0, OpCode=0, enReg=RegWrite=OpValid=Busy=0.
REQ-033 Reset asserted mid-instruction discards it immediately; no RegWrite is produced afterwards.

Structure
REQ-034 A shared package holds the state enumeration, the instruction field bit positions and WB_OPC_MAX.
REQ-035 Field extraction and the write-back decision live in one combinational sub-module, instr_field_decode; the FSM and the operand/result registers are in the top module.

Verification
REQ-036 R2=0x0005, R3=0x0007; Instr=0x0298 (op0, Rd1, Rs1=2, Rs2=3) -> enReg 1 cycle with RA=2, RB=3; OpA=0x0005, OpB=0x0007, OpValid at k+3; Result=0x000C -> RegWrite 1 cycle, RW=1, BusW=0x000C.
REQ-037 Instr=0x0098 (Rd=0), Result=0x1234 -> WB entered, RegWrite stays 0, IDLE next cycle.
REQ-038 Instr=0x5298 (store class) -> after OpReady, next state IDLE, no EXEC, no RegWrite, InstrReady=1.
REQ-039 OpReady held 0 for 5 cycles in ISSUE -> OpValid=1 and OpA/OpB/OpCode stable throughout; a stray ResValid pulse is ignored.
REQ-040 Flush=1 in EXEC -> IDLE next cycle, no RegWrite; Reset_n=0 mid-CAPT -> outputs at reset values immediately, InstrReady=1.

Source files
------------

// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller: FSM state codes,
// instruction field positions and the default write-back opcode limit.
package operand_fetch_ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 16;
  localparam int REG_AW  = 3;
  localparam int OPC_W   = 4;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  // Opcodes 0..WB_OPC_MAX produce a result that is written back to Rd.
  localparam logic [OPC_W-1:0] WB_OPC_MAX = 4'h4;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_READ  = 3'd1;
  localparam logic [ST_W-1:0] ST_CAPT  = 3'd2;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd3;
  localparam logic [ST_W-1:0] ST_EXEC  = 3'd4;
  localparam logic [ST_W-1:0] ST_WB    = 3'd5;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } instr_fields_t;

endpackage

// File: rtl/operand_fetch_ctrl_instr_field_decode.sv
// Splits an instruction word into its register/opcode fields and decides
// whether the opcode writes a result back to Rd.
module instr_field_decode #(
  parameter logic [3:0] WB_OPC_MAX = operand_fetch_ctrl_pkg::WB_OPC_MAX
) (
  input  logic [operand_fetch_ctrl_pkg::INSTR_W-1:0] i_instr,
  output operand_fetch_ctrl_pkg::instr_fields_t      o_fields,
  output logic                                       o_wb
);
  import operand_fetch_ctrl_pkg::*;

  logic w_unused;

  always_comb begin
    o_fields.opcode = i_instr[OPC_HI:OPC_LO];
    o_fields.rd     = i_instr[RD_HI:RD_LO];
    o_fields.rs1    = i_instr[RS1_HI:RS1_LO];
    o_fields.rs2    = i_instr[RS2_HI:RS2_LO];
  end

  assign o_wb = (i_instr[OPC_HI:OPC_LO] <= WB_OPC_MAX);

  // Low three bits carry no information in this instruction format.
  assign w_unused = ^i_instr[RS2_LO-1:0];

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: accepts an instruction, reads two operands from
// the register file, issues them to execute and writes the result back.
module operand_fetch_ctrl #(
  parameter logic [3:0] WB_OPC_MAX = operand_fetch_ctrl_pkg::WB_OPC_MAX
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] Instr,
  input  logic        InstrValid,
  output logic        InstrReady,
  output logic [2:0]  RA,
  output logic [2:0]  RB,
  output logic [2:0]  RW,
  output logic        enReg,
  output logic        RegWrite,
  output logic [15:0] BusW,
  input  logic [15:0] BusA,
  input  logic [15:0] BusB,
  output logic        OpValid,
  input  logic        OpReady,
  output logic [15:0] OpA,
  output logic [15:0] OpB,
  output logic [3:0]  OpCode,
  input  logic        ResValid,
  input  logic [15:0] Result,
  input  logic        Flush,
  output logic        Busy
);
  import operand_fetch_ctrl_pkg::*;

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_next;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_opa;
  logic [DATA_W-1:0]  r_opb;
  logic [DATA_W-1:0]  r_busw;

  instr_fields_t      w_fields;
  logic               w_wb;
  logic               w_accept;
  logic               w_capture;
  logic               w_res_take;

  instr_field_decode #(
    .WB_OPC_MAX (WB_OPC_MAX)
  ) u_decode (
    .i_instr  (r_instr),
    .o_fields (w_fields),
    .o_wb     (w_wb)
  );

  assign w_accept   = (r_state == ST_IDLE) && InstrValid;
  assign w_capture  = (r_state == ST_CAPT) && !Flush;
  assign w_res_take = (r_state == ST_EXEC) && ResValid && !Flush;

  // Flush aborts only the stages that still own an instruction; WB always completes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (InstrValid) w_state_next = ST_READ;
      ST_READ:  w_state_next = Flush ? ST_IDLE : ST_CAPT;
      ST_CAPT:  w_state_next = Flush ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: begin
        if (Flush)        w_state_next = ST_IDLE;
        else if (OpReady) w_state_next = w_wb ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        if (Flush)         w_state_next = ST_IDLE;
        else if (ResValid) w_state_next = ST_WB;
      end
      ST_WB:    w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_instr <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_busw  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept)   r_instr <= Instr;
      if (w_capture) begin
        r_opa <= BusA;
        r_opb <= BusB;
      end
      if (w_res_take) r_busw <= Result;
    end
  end

  // Addresses are driven only in the cycle that uses them, zero otherwise.
  always_comb begin
    RA       = (r_state == ST_READ) ? w_fields.rs1 : '0;
    RB       = (r_state == ST_READ) ? w_fields.rs2 : '0;
    RW       = (r_state == ST_WB)   ? w_fields.rd  : '0;
    enReg    = (r_state == ST_READ);
    RegWrite = (r_state == ST_WB) && (w_fields.rd != '0);
  end

  assign InstrReady = (r_state == ST_IDLE);
  assign Busy       = (r_state != ST_IDLE);
  assign OpValid    = (r_state == ST_ISSUE);
  assign OpA        = r_opa;
  assign OpB        = r_opb;
  assign OpCode     = w_fields.opcode;
  assign BusW       = r_busw;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Self-checking bench for operand_fetch_ctrl: directed scenarios plus a
// randomized run scored against a transaction-level register-file model.
module tb_operand_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] Instr = '0;
  logic        InstrValid = 1'b0;
  logic        InstrReady;
  logic [2:0]  RA, RB, RW;
  logic        enReg, RegWrite;
  logic [15:0] BusW;
  logic [15:0] BusA = '0;
  logic [15:0] BusB = '0;
  logic        OpValid;
  logic        OpReady = 1'b0;
  logic [15:0] OpA, OpB;
  logic [3:0]  OpCode;
  logic        ResValid = 1'b0;
  logic [15:0] Result = '0;
  logic        Flush = 1'b0;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  operand_fetch_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .RA         (RA),
    .RB         (RB),
    .RW         (RW),
    .enReg      (enReg),
    .RegWrite   (RegWrite),
    .BusW       (BusW),
    .BusA       (BusA),
    .BusB       (BusB),
    .OpValid    (OpValid),
    .OpReady    (OpReady),
    .OpA        (OpA),
    .OpB        (OpB),
    .OpCode     (OpCode),
    .ResValid   (ResValid),
    .Result     (Result),
    .Flush      (Flush),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Register file environment: registered read on enReg, write on RegWrite.
  logic [15:0] env_rf [8];
  logic [15:0] model_rf [8];

  always @(posedge Clk) begin
    if (enReg) begin
      BusA <= env_rf[RA];
      BusB <= env_rf[RB];
    end
    if (RegWrite) env_rf[RW] <= BusW;
  end

  // Observations of one instruction, cycle n counted from the accept edge.
  int          ob_en_cnt, ob_en_n, ob_both, ob_opv_n, ob_opv_cycles;
  int          ob_unstable, ob_rw_cnt, ob_end_n;
  logic [2:0]  ob_ra, ob_rb, ob_rw;
  logic [15:0] ob_opa, ob_opb, ob_busw;
  logic [3:0]  ob_opc;
  logic        ob_acc_ready, ob_end_ready;

  task automatic run_instr(input logic [15:0] instr, input int stall,
                           input int res_delay, input logic [15:0] result,
                           input int flush_n, input logic flush_exec,
                           input logic flush_wb, input logic flush_idle,
                           input logic stray);
    logic post;
    int   p;
    ob_en_cnt = 0; ob_en_n = -1; ob_both = 0; ob_opv_n = -1;
    ob_opv_cycles = 0; ob_unstable = 0; ob_rw_cnt = 0; ob_end_n = -1;
    ob_ra = '0; ob_rb = '0; ob_rw = '0; ob_opa = '0; ob_opb = '0;
    ob_busw = '0; ob_opc = '0; ob_end_ready = 1'b0;
    post = 1'b0;
    p = 0;
    @(negedge Clk);
    Instr = instr;
    InstrValid = 1'b1;
    Flush = flush_idle;
    ob_acc_ready = InstrReady;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clk);
      InstrValid = 1'b0;
      Flush = 1'b0;
      ResValid = 1'b0;
      Instr = 16'($urandom);
      Result = 16'($urandom);
      OpReady = stray ? 1'($urandom) : 1'b0;
      if (!Busy) begin
        ob_end_n = n;
        ob_end_ready = InstrReady;
        break;
      end
      if (enReg) begin
        ob_en_cnt++;
        ob_en_n = n;
        ob_ra = RA;
        ob_rb = RB;
      end
      if (enReg && RegWrite) ob_both++;
      if (RegWrite) begin
        ob_rw_cnt++;
        ob_rw = RW;
        ob_busw = BusW;
      end
      if (OpValid) begin
        ob_opv_cycles++;
        if (ob_opv_n < 0) begin
          ob_opv_n = n;
          ob_opa = OpA;
          ob_opb = OpB;
          ob_opc = OpCode;
        end else if (OpA !== ob_opa || OpB !== ob_opb || OpCode !== ob_opc) begin
          ob_unstable++;
        end
        OpReady = (n - ob_opv_n >= stall);
        if (stray && stall > 0 && n == ob_opv_n) ResValid = 1'b1;
        if (OpReady) post = 1'b1;
      end else if (post) begin
        if (flush_exec && p == 0) Flush = 1'b1;
        else if (p == res_delay) begin
          ResValid = 1'b1;
          Result = result;
        end
        if (flush_wb && p == res_delay + 1) Flush = 1'b1;
        p++;
      end
      if (flush_n == n) Flush = 1'b1;
    end
    Flush = 1'b0;
    ResValid = 1'b0;
    OpReady = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if (InstrReady !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: InstrReady=%b Busy=%b required 1/0", InstrReady, Busy);
    end
    checks++;
    if ({enReg, RegWrite, OpValid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: enReg/RegWrite/OpValid=%b required 000", {enReg, RegWrite, OpValid});
    end
    checks++;
    if ({OpA, OpB, BusW} !== 48'h0 || {RA, RB, RW, OpCode} !== 13'h0) begin
      errors++;
      $display("FAIL reset_data: OpA=%h OpB=%h BusW=%h RA=%0d RB=%0d RW=%0d OpCode=%h required all 0",
               OpA, OpB, BusW, RA, RB, RW, OpCode);
    end
    Reset_n = 1'b1;
    $display("reset: InstrReady=%b Busy=%b", InstrReady, Busy);
  endtask

  task automatic test_basic();
    run_instr(16'h0298, 0, 0, 16'h000C, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ob_acc_ready !== 1'b1) begin
      errors++; $display("FAIL basic_accept: InstrReady=%b required 1", ob_acc_ready);
    end
    checks++;
    if (ob_en_cnt != 1 || ob_en_n != 1 || ob_ra !== 3'd2 || ob_rb !== 3'd3) begin
      errors++;
      $display("FAIL basic_read: enReg cycles=%0d at=%0d RA=%0d RB=%0d required 1 at 1 RA=2 RB=3",
               ob_en_cnt, ob_en_n, ob_ra, ob_rb);
    end
    checks++;
    if (ob_opv_n != 3 || ob_opa !== 16'h0005 || ob_opb !== 16'h0007 || ob_opc !== 4'h0) begin
      errors++;
      $display("FAIL basic_issue: OpValid at=%0d OpA=%h OpB=%h OpCode=%h required 3 0005 0007 0",
               ob_opv_n, ob_opa, ob_opb, ob_opc);
    end
    checks++;
    if (ob_rw_cnt != 1 || ob_rw !== 3'd1 || ob_busw !== 16'h000C || ob_both != 0) begin
      errors++;
      $display("FAIL basic_wb: RegWrite cycles=%0d RW=%0d BusW=%h overlap=%0d required 1 1 000c 0",
               ob_rw_cnt, ob_rw, ob_busw, ob_both);
    end
    checks++;
    if (ob_end_n != 6) begin
      errors++; $display("FAIL basic_idle: idle at=%0d required 6", ob_end_n);
    end
    model_rf[1] = 16'h000C;
    $display("basic: instr=0298 OpA=%h OpB=%h RW=%0d BusW=%h idle_at=%0d", ob_opa, ob_opb, ob_rw, ob_busw, ob_end_n);
  endtask

  task automatic test_rd0();
    run_instr(16'h0098, 0, 0, 16'h1234, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ob_rw_cnt != 0 || ob_end_n != 6) begin
      errors++;
      $display("FAIL rd0_wb: RegWrite cycles=%0d idle at=%0d required 0 and 6", ob_rw_cnt, ob_end_n);
    end
    checks++;
    if (BusW !== 16'h1234) begin
      errors++; $display("FAIL rd0_busw: BusW=%h required 1234", BusW);
    end
    $display("rd0: instr=0098 RegWrite_cycles=%0d BusW=%h idle_at=%0d", ob_rw_cnt, BusW, ob_end_n);
  endtask

  task automatic test_store();
    run_instr(16'h5298, 0, 0, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ob_end_n != 4 || ob_rw_cnt != 0 || ob_end_ready !== 1'b1 || ob_opc !== 4'h5) begin
      errors++;
      $display("FAIL store_no_exec: idle at=%0d RegWrite cycles=%0d InstrReady=%b OpCode=%h required 4 0 1 5",
               ob_end_n, ob_rw_cnt, ob_end_ready, ob_opc);
    end
    $display("store: instr=5298 idle_at=%0d InstrReady=%b", ob_end_n, ob_end_ready);
  endtask

  task automatic test_stall();
    logic [15:0] res;
    res = 16'hA5C3;
    run_instr(16'h1898, 5, 1, res, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (ob_opv_n != 3 || ob_opv_cycles != 6 || ob_unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: OpValid at=%0d cycles=%0d unstable=%0d required 3 6 0",
               ob_opv_n, ob_opv_cycles, ob_unstable);
    end
    checks++;
    if (ob_opa !== model_rf[2] || ob_opb !== model_rf[3] || ob_opc !== 4'h1) begin
      errors++;
      $display("FAIL stall_operands: OpA=%h OpB=%h OpCode=%h required %h %h 1",
               ob_opa, ob_opb, ob_opc, model_rf[2], model_rf[3]);
    end
    checks++;
    if (ob_end_n != 12 || ob_rw_cnt != 1 || ob_rw !== 3'd4 || ob_busw !== res) begin
      errors++;
      $display("FAIL stall_wb: idle at=%0d RegWrite cycles=%0d RW=%0d BusW=%h required 12 1 4 %h",
               ob_end_n, ob_rw_cnt, ob_rw, ob_busw, res);
    end
    model_rf[4] = res;
    $display("stall: instr=1898 opvalid_cycles=%0d RW=%0d BusW=%h idle_at=%0d", ob_opv_cycles, ob_rw, ob_busw, ob_end_n);
  endtask

  task automatic test_flush();
    run_instr(16'h0298, 0, 0, 16'h7777, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ob_end_n != 5 || ob_rw_cnt != 0) begin
      errors++;
      $display("FAIL flush_exec: idle at=%0d RegWrite cycles=%0d required 5 0", ob_end_n, ob_rw_cnt);
    end
    $display("flush_exec: idle_at=%0d RegWrite_cycles=%0d", ob_end_n, ob_rw_cnt);
    run_instr(16'h0C98, 0, 0, 16'h3131, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ob_end_n != 3 || ob_opv_n != -1 || ob_rw_cnt != 0) begin
      errors++;
      $display("FAIL flush_capt: idle at=%0d OpValid at=%0d RegWrite cycles=%0d required 3 -1 0",
               ob_end_n, ob_opv_n, ob_rw_cnt);
    end
    $display("flush_capt: idle_at=%0d", ob_end_n);
    run_instr(16'h0A98, 0, 0, 16'h4242, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (ob_en_cnt != 1 || ob_end_n != 6 || ob_rw_cnt != 1 || ob_rw !== 3'd5 || ob_busw !== 16'h4242) begin
      errors++;
      $display("FAIL flush_ignored: enReg cycles=%0d idle at=%0d RegWrite cycles=%0d RW=%0d BusW=%h required 1 6 1 5 4242",
               ob_en_cnt, ob_end_n, ob_rw_cnt, ob_rw, ob_busw);
    end
    model_rf[5] = 16'h4242;
    $display("flush_idle_wb: RW=%0d BusW=%h idle_at=%0d", ob_rw, ob_busw, ob_end_n);
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    int busy_seen;
    wr_seen = 0;
    busy_seen = 0;
    @(negedge Clk);
    Instr = 16'h0298;
    InstrValid = 1'b1;
    @(negedge Clk);
    InstrValid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (InstrReady !== 1'b1 || Busy !== 1'b0 || {enReg, RegWrite, OpValid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ctrl: InstrReady=%b Busy=%b strobes=%b required 1 0 000",
               InstrReady, Busy, {enReg, RegWrite, OpValid});
    end
    checks++;
    if ({OpA, OpB, BusW} !== 48'h0 || {RA, RB, RW, OpCode} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_data: OpA=%h OpB=%h BusW=%h RA=%0d RB=%0d RW=%0d OpCode=%h required all 0",
               OpA, OpB, BusW, RA, RB, RW, OpCode);
    end
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ResValid = 1'b1;
      OpReady = 1'b1;
      @(negedge Clk);
      if (RegWrite) wr_seen++;
      if (Busy) busy_seen++;
    end
    ResValid = 1'b0;
    OpReady = 1'b0;
    checks++;
    if (wr_seen != 0 || busy_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_after: RegWrite cycles=%0d Busy cycles=%0d required 0 0", wr_seen, busy_seen);
    end
    $display("reset_mid: RegWrite_cycles=%0d Busy_cycles=%0d", wr_seen, busy_seen);
  endtask

  task automatic test_random();
    logic [15:0] instr, res;
    logic [3:0]  opc;
    logic [2:0]  rd, rs1, rs2;
    int          stall, rdly, mode, fl_n, exp_end, exp_opv, exp_rw;
    logic        fl_exec, fl_wb, wb;
    for (int t = 0; t < 40; t++) begin
      opc = 4'($urandom_range(0, 15));
      rd  = 3'($urandom);
      rs1 = 3'($urandom);
      rs2 = 3'($urandom);
      instr = {opc, rd, rs1, rs2, 3'($urandom)};
      res = 16'($urandom);
      stall = $urandom_range(0, 3);
      rdly = $urandom_range(0, 3);
      mode = $urandom_range(0, 7);
      fl_n = (mode == 0) ? $urandom_range(1, 3) : 0;
      fl_exec = (mode == 1);
      fl_wb = (mode == 2);
      run_instr(instr, stall, rdly, res, fl_n, fl_exec, fl_wb, 1'b0, 1'b1);
      wb = (opc <= 4'h4);
      if (fl_n > 0)     exp_end = fl_n + 1;
      else if (!wb)     exp_end = 4 + stall;
      else if (fl_exec) exp_end = 5 + stall;
      else              exp_end = 6 + stall + rdly;
      exp_opv = (fl_n == 1 || fl_n == 2) ? -1 : 3;
      exp_rw = (wb && fl_n == 0 && !fl_exec && rd != 3'd0) ? 1 : 0;
      checks++;
      if (ob_end_n != exp_end || ob_en_n != 1 || ob_en_cnt != 1 || ob_opv_n != exp_opv || ob_both != 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: idle=%0d en=%0d/%0d opv=%0d overlap=%0d required idle=%0d en=1/1 opv=%0d overlap=0",
                 t, ob_end_n, ob_en_n, ob_en_cnt, ob_opv_n, ob_both, exp_end, exp_opv);
      end
      checks++;
      if (ob_ra !== rs1 || ob_rb !== rs2 ||
          (exp_opv > 0 && (ob_opa !== model_rf[rs1] || ob_opb !== model_rf[rs2] || ob_opc !== opc))) begin
        errors++;
        $display("FAIL rand_operands[%0d]: RA=%0d RB=%0d OpA=%h OpB=%h OpCode=%h required %0d %0d %h %h %h",
                 t, ob_ra, ob_rb, ob_opa, ob_opb, ob_opc, rs1, rs2, model_rf[rs1], model_rf[rs2], opc);
      end
      checks++;
      if (ob_rw_cnt != exp_rw || (exp_rw == 1 && (ob_rw !== rd || ob_busw !== res))) begin
        errors++;
        $display("FAIL rand_wb[%0d]: RegWrite cycles=%0d RW=%0d BusW=%h required %0d RW=%0d BusW=%h",
                 t, ob_rw_cnt, ob_rw, ob_busw, exp_rw, rd, res);
      end
      if (exp_rw == 1) model_rf[rd] = res;
      $display("rand[%0d]: instr=%h stall=%0d rdly=%0d mode=%0d idle_at=%0d writes=%0d",
               t, instr, stall, rdly, mode, ob_end_n, ob_rw_cnt);
    end
    @(negedge Clk);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (env_rf[r] !== model_rf[r]) begin
        errors++;
        $display("FAIL rf_contents[%0d]: got %h required %h", r, env_rf[r], model_rf[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) begin
      env_rf[r] = 16'($urandom);
      model_rf[r] = env_rf[r];
    end
    env_rf[2] = 16'h0005; model_rf[2] = 16'h0005;
    env_rf[3] = 16'h0007; model_rf[3] = 16'h0007;
    test_reset();
    test_basic();
    test_rd0();
    test_store();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
